// File: rtl/fetch_decode_queue.sv
// Fetch-to-decode instruction queue: circular FIFO of {PC, instruction} pairs
// with a valid/ready handshake toward decode and a redirect flush.
module fetch_decode_queue #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       valid_F,
  output logic                       ready_F,
  input  logic [31:0]                instruction_F,
  input  logic [31:0]                PC_F,
  input  logic                       flush,
  output logic                       valid_D,
  input  logic                       ready_D,
  output logic [31:0]                instruction_D,
  output logic [31:0]                PC_D,
  output logic [31:0]                PC_plus4_D,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);
  localparam logic [AW:0]   CNT_ONE    = (AW + 1)'(1);

  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          push;
  logic          pop;

  assign full    = (count == FULL_COUNT);
  assign ready_F = ~full;
  assign valid_D = (count != '0);
  assign push    = valid_F & ready_F & ~flush;
  assign pop     = valid_D & ready_D & ~flush;

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= PC_F;
      instr_mem[wr_ptr] <= instruction_F;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Sticky: a fetch attempt against a full queue means fetch failed to stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (valid_F && full && !flush) begin
      overflow <= 1'b1;
    end
  end

  always_comb begin
    instruction_D = NOP_INSTR;
    PC_D          = '0;
    PC_plus4_D    = '0;
    if (valid_D) begin
      instruction_D = instr_mem[rd_ptr];
      PC_D          = pc_mem[rd_ptr];
      PC_plus4_D    = pc_mem[rd_ptr] + 32'd4;
    end
  end

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Directed bench for fetch_decode_queue (DEPTH=4) with hand-computed expectations.
module tb_fetch_decode_queue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        valid_F = 1'b0;
  logic        ready_F;
  logic [31:0] instruction_F = '0;
  logic [31:0] PC_F = '0;
  logic        flush = 1'b0;
  logic        valid_D;
  logic        ready_D = 1'b0;
  logic [31:0] instruction_D;
  logic [31:0] PC_D;
  logic [31:0] PC_plus4_D;
  logic [2:0]  count;
  logic        overflow;

  int unsigned passed = 0;
  int unsigned total  = 0;

  fetch_decode_queue #(.DEPTH(4), .NOP_INSTR(32'h00000013)) dut (
    .clk(clk), .rst_n(rst_n),
    .valid_F(valid_F), .ready_F(ready_F),
    .instruction_F(instruction_F), .PC_F(PC_F),
    .flush(flush),
    .valid_D(valid_D), .ready_D(ready_D),
    .instruction_D(instruction_D), .PC_D(PC_D), .PC_plus4_D(PC_plus4_D),
    .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, observed, expected);
  endtask

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] exp_pc;

    // Asynchronous reset mid-cycle
    cyc(); cyc();
    #3 rst_n = 1'b0;
    #1;
    chk("rst_valid", 32'(valid_D), 32'd0);
    chk("rst_instr", instruction_D, 32'h00000013);
    chk("rst_pc", PC_D, 32'h0);
    chk("rst_pc4", PC_plus4_D, 32'h0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_readyF", 32'(ready_F), 32'd1);
    chk("rst_ovf", 32'(overflow), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    cyc();
    chk("idle_valid", 32'(valid_D), 32'd0);

    // Streaming
    ready_D = 1'b1; valid_F = 1'b1;
    PC_F = 32'h0; instruction_F = 32'hA;
    cyc();
    chk("s0_count", 32'(count), 32'd1);
    chk("s0_pc", PC_D, 32'h0);
    chk("s0_instr", instruction_D, 32'hA);
    chk("s0_pc4", PC_plus4_D, 32'h4);
    PC_F = 32'h4; instruction_F = 32'hB;
    cyc();
    chk("s1_count", 32'(count), 32'd1);
    chk("s1_pc", PC_D, 32'h4);
    chk("s1_instr", instruction_D, 32'hB);
    PC_F = 32'h8; instruction_F = 32'hC;
    cyc();
    chk("s2_count", 32'(count), 32'd1);
    chk("s2_pc", PC_D, 32'h8);
    chk("s2_instr", instruction_D, 32'hC);
    valid_F = 1'b0;
    cyc();
    chk("s3_count", 32'(count), 32'd0);
    chk("s3_valid", 32'(valid_D), 32'd0);
    chk("s3_instr", instruction_D, 32'h00000013);

    // Fill and stall: fifth push is refused and raises overflow
    ready_D = 1'b0; valid_F = 1'b1;
    for (int i = 0; i < 5; i++) begin
      PC_F = 32'(4 * i); instruction_F = 32'h100 + 32'(i);
      cyc();
      chk("fill_count", 32'(count), (i < 4) ? 32'(i + 1) : 32'd4);
      chk("fill_head", PC_D, 32'h0);
      if (i == 3) begin
        chk("fill_readyF", 32'(ready_F), 32'd0);
        chk("fill_ovf_pre", 32'(overflow), 32'd0);
      end
    end
    chk("fill_ovf", 32'(overflow), 32'd1);
    chk("fill_readyF2", 32'(ready_F), 32'd0);
    valid_F = 1'b0; ready_D = 1'b1;
    for (int j = 0; j < 4; j++) begin
      chk("drain_pc", PC_D, 32'(4 * j));
      chk("drain_instr", instruction_D, 32'h100 + 32'(j));
      cyc();
    end
    chk("drain_valid", 32'(valid_D), 32'd0);
    chk("drain_ovf", 32'(overflow), 32'd1);

    // Simultaneous push and pop at count 2
    ready_D = 1'b0; valid_F = 1'b1;
    PC_F = 32'h20; instruction_F = 32'h20A; cyc();
    PC_F = 32'h24; instruction_F = 32'h24A; cyc();
    chk("pp_count0", 32'(count), 32'd2);
    PC_F = 32'h28; instruction_F = 32'h28A; ready_D = 1'b1;
    cyc();
    chk("pp_count", 32'(count), 32'd2);
    chk("pp_pc", PC_D, 32'h24);
    valid_F = 1'b0;
    cyc();
    chk("pp_count1", 32'(count), 32'd1);
    chk("pp_pc2", PC_D, 32'h28);
    chk("pp_instr2", instruction_D, 32'h28A);
    cyc();
    chk("pp_empty", 32'(count), 32'd0);

    // Flush discards entries and the same-cycle push
    ready_D = 1'b0; valid_F = 1'b1;
    PC_F = 32'h30; cyc();
    PC_F = 32'h34; cyc();
    PC_F = 32'h38; cyc();
    chk("fl_count3", 32'(count), 32'd3);
    PC_F = 32'h100; ready_D = 1'b1; flush = 1'b1;
    cyc();
    chk("fl_count", 32'(count), 32'd0);
    chk("fl_valid", 32'(valid_D), 32'd0);
    chk("fl_pc", PC_D, 32'h0);
    chk("fl_ovf", 32'(overflow), 32'd1);
    flush = 1'b0; ready_D = 1'b0;
    PC_F = 32'h200; instruction_F = 32'h2000;
    cyc();
    chk("fl_next_pc", PC_D, 32'h200);
    chk("fl_next_cnt", 32'(count), 32'd1);
    valid_F = 1'b0; ready_D = 1'b1;
    cyc();
    chk("fl_drain", 32'(count), 32'd0);

    // Wrap pointers twice; final PC wraps PC+4 to zero
    valid_F = 1'b1; ready_D = 1'b1;
    for (int i = 0; i < 10; i++) begin
      PC_F = (i == 9) ? 32'hFFFFFFFC : 32'h1000 + 32'(4 * i);
      instruction_F = 32'h3000 + 32'(i);
      cyc();
      exp_pc = (i == 9) ? 32'hFFFFFFFC : 32'h1000 + 32'(4 * i);
      chk("wr_pc", PC_D, exp_pc);
      chk("wr_instr", instruction_D, 32'h3000 + 32'(i));
      chk("wr_count", 32'(count), 32'd1);
    end
    chk("wr_pc4_wrap", PC_plus4_D, 32'h0);

    // Reset mid-operation empties the queue without a clock edge
    ready_D = 1'b0;
    PC_F = 32'h500; cyc();
    valid_F = 1'b0;
    chk("rr_count_pre", 32'(count), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("rr_count", 32'(count), 32'd0);
    chk("rr_valid", 32'(valid_D), 32'd0);
    chk("rr_ovf", 32'(overflow), 32'd0);
    chk("rr_instr", instruction_D, 32'h00000013);
    @(negedge clk) rst_n = 1'b1;
    cyc();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
